sev_seg_counter: RTL and testbench

Parametrised display-value generator that feeds the seven-segment driver. It generalises the fixed 4-digit hex demo counter in four ways: configurable digit count, hex or BCD counting, up/down direction, and run/pause/load control. It has no derived clocks: every register runs on `clk_50MHz`, and timing comes from single-cycle tick enables. The block sits between user controls and `sev_segdriver`. Its `scan_tick` output is the driver's refresh enable, and `digits_out` is the driver's per-digit data bus.

---
 rtl/sev_seg_pkg.sv | 11 +
 rtl/sev_seg_tick.sv | 33 +++
 rtl/sev_seg_counter.sv | 101 ++++++++++
 tb/tb_sev_seg_counter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sev_seg_pkg.sv
// Shared constants for the seven-segment display counter.
// Digit format, dp polarity and counting modes.
package sev_seg_pkg;

  localparam int DIGIT_W = 5;
  localparam logic DP_OFF = 1'b1;
  localparam int MODE_HEX = 0;
  localparam int MODE_BCD = 1;
  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/sev_seg_tick.sv
// Prescaler producing a one-cycle tick every DIV enabled cycles.
// Holds its phase while en is low; clr restarts the period.
module sev_seg_tick #(
  parameter int DIV = 4
) (
  input  logic clk_50MHz,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;
  logic at_last;

  assign at_last = (cnt == LAST);
  assign tick = en && at_last;

  // Period counter: clear wins, otherwise advance while enabled.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/sev_seg_counter.sv
// Hex/BCD up/down display counter feeding sev_segdriver.
// Single clock; count and scan timing come from tick enables.
module sev_seg_counter
  import sev_seg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int BCD       = 0,
  parameter int COUNT_DIV = 2097152,
  parameter int SCAN_DIV  = 131072
) (
  input  logic                    clk_50MHz,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*DIGITS-1:0]     load_value,
  input  logic [DIGITS-1:0]       dp_en,
  output logic [DIGIT_W*DIGITS-1:0] digits_out,
  output logic                    scan_tick,
  output logic                    count_tick,
  output logic                    wrap
);

  localparam logic [3:0] DMAX =
    (BCD == MODE_BCD) ? BCD_MAX : 4'hF;

  logic [4*DIGITS-1:0]       value;
  logic [4*DIGITS-1:0]       step_v;
  logic [4*DIGITS-1:0]       load_v;
  logic [4*DIGITS-1:0]       nxt_v;
  logic [DIGIT_W*DIGITS-1:0] dig_nx;
  logic [DIGITS:0]           carry;
  logic                      wrap_nx;

  sev_seg_tick #(.DIV(SCAN_DIV)) u_scan (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .en        (1'b1),
    .clr       (1'b0),
    .tick      (scan_tick)
  );

  sev_seg_tick #(.DIV(COUNT_DIV)) u_count (
    .clk_50MHz (clk_50MHz),
    .rst_n     (rst_n),
    .en        (run),
    .clr       (load),
    .tick      (count_tick)
  );

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    logic [3:0] d;
    logic [3:0] ld;
    logic       lim;

    assign d   = value[4*i +: 4];
    assign ld  = load_value[4*i +: 4];
    assign lim = up ? (d == DMAX) : (d == 4'd0);

    assign step_v[4*i +: 4] =
      !carry[i] ? d :
      lim       ? (up ? 4'd0 : DMAX) :
      up        ? d + 4'd1 : d - 4'd1;

    assign carry[i+1] = carry[i] & lim;

    assign load_v[4*i +: 4] =
      (BCD == MODE_BCD && ld > BCD_MAX) ? 4'd0 : ld;

    assign dig_nx[DIGIT_W*i +: DIGIT_W] =
      {~dp_en[i], nxt_v[4*i +: 4]};
  end

  // Next value: load beats a count step, otherwise hold.
  always_comb begin
    nxt_v = value;
    wrap_nx = 1'b0;
    if (load) begin
      nxt_v = load_v;
    end else if (count_tick) begin
      nxt_v = step_v;
      wrap_nx = carry[DIGITS];
    end
  end

  // Value, driver bus and wrap pulse update together.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      value      <= '0;
      digits_out <= {DIGITS{{DP_OFF, 4'h0}}};
      wrap       <= 1'b0;
    end else begin
      value      <= nxt_v;
      digits_out <= dig_nx;
      wrap       <= wrap_nx;
    end
  end

endmodule

// File: tb/tb_sev_seg_counter.sv
// Directed bench for sev_seg_counter, hex and BCD builds.
// Both instances share stimulus; each is checked separately.
module tb_sev_seg_counter;

  logic       clk_50MHz;
  logic       rst_n;
  logic       run;
  logic       up;
  logic       load;
  logic [7:0] load_value;
  logic [1:0] dp_en;

  logic [9:0] do_h, do_b;
  logic       st_h, st_b;
  logic       ct_h, ct_b;
  logic       wr_h, wr_b;

  int n_chk;
  int n_pass;

  sev_seg_counter #(
    .DIGITS(2), .BCD(0), .COUNT_DIV(4), .SCAN_DIV(2)
  ) u_hex (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .run        (run),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .dp_en      (dp_en),
    .digits_out (do_h),
    .scan_tick  (st_h),
    .count_tick (ct_h),
    .wrap       (wr_h)
  );

  sev_seg_counter #(
    .DIGITS(2), .BCD(1), .COUNT_DIV(4), .SCAN_DIV(2)
  ) u_bcd (
    .clk_50MHz  (clk_50MHz),
    .rst_n      (rst_n),
    .run        (run),
    .up         (up),
    .load       (load),
    .load_value (load_value),
    .dp_en      (dp_en),
    .digits_out (do_b),
    .scan_tick  (st_b),
    .count_tick (ct_b),
    .wrap       (wr_b)
  );

  initial clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  typedef struct {
    logic [7:0] lv;
    logic [7:0] hx;
    logic [7:0] bc;
  } ld_vec_t;

  typedef struct {
    logic [7:0] st;
    logic [7:0] bst;
    logic       up;
    logic [7:0] hx;
    logic       hw;
    logic [7:0] bc;
    logic       bw;
  } st_vec_t;

  ld_vec_t lt[8];
  st_vec_t sv[7];

  function automatic logic [9:0] mk(
    input logic [7:0] v,
    input logic [1:0] dp
  );
    return {~dp[1], v[7:4], ~dp[0], v[3:0]};
  endfunction

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_value = v;
    nclk(1);
    load = 1'b0;
  endtask

  int sc;

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    run = 1'b0;
    up = 1'b1;
    load = 1'b0;
    load_value = 8'h00;
    dp_en = 2'b00;

    lt[0] = '{8'h00, 8'h00, 8'h00};
    lt[1] = '{8'h37, 8'h37, 8'h37};
    lt[2] = '{8'hFF, 8'hFF, 8'h00};
    lt[3] = '{8'h99, 8'h99, 8'h99};
    lt[4] = '{8'hAB, 8'hAB, 8'h00};
    lt[5] = '{8'h9A, 8'h9A, 8'h90};
    lt[6] = '{8'hA9, 8'hA9, 8'h09};
    lt[7] = '{8'h5C, 8'h5C, 8'h50};

    sv[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 8'h01, 1'b0};
    sv[1] = '{8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 8'h99, 1'b1};
    sv[2] = '{8'h09, 8'h09, 1'b1, 8'h0A, 1'b0, 8'h10, 1'b0};
    sv[3] = '{8'h99, 8'h99, 1'b1, 8'h9A, 1'b0, 8'h00, 1'b1};
    sv[4] = '{8'h10, 8'h10, 1'b0, 8'h0F, 1'b0, 8'h09, 1'b0};
    sv[5] = '{8'h3F, 8'h30, 1'b1, 8'h40, 1'b0, 8'h31, 1'b0};
    sv[6] = '{8'hA0, 8'h00, 1'b0, 8'h9F, 1'b0, 8'h99, 1'b1};

    // reset state
    nclk(2);
    chk("rst_do_h", 32'(do_h), 32'h210);
    chk("rst_do_b", 32'(do_b), 32'h210);
    chk("rst_ticks", {st_h, ct_h, wr_h, st_b, ct_b, wr_b}, 0);

    // first scan and count ticks after release
    run = 1'b1;
    rst_n = 1'b1;
    nclk(1);
    chk("scan1", 32'(st_h), 1);
    chk("ct1", 32'(ct_h), 0);
    nclk(1);
    chk("scan2", 32'(st_h), 0);
    nclk(1);
    chk("ct3", 32'(ct_h), 1);
    chk("scan3", 32'(st_h), 1);
    chk("do3", 32'(do_h), 32'(mk(8'h00, 2'b00)));
    nclk(1);
    chk("first_step_h", 32'(do_h), 32'h211);
    chk("first_step_b", 32'(do_b), 32'h211);
    chk("first_wrap", 32'(wr_h), 0);
    run = 1'b0;

    // load table
    for (int i = 0; i < 8; i++) begin
      do_load(lt[i].lv);
      chk($sformatf("ld_h[%0d]", i), 32'(do_h),
          32'(mk(lt[i].hx, 2'b00)));
      chk($sformatf("ld_b[%0d]", i), 32'(do_b),
          32'(mk(lt[i].bc, 2'b00)));
      chk($sformatf("ld_w[%0d]", i), {wr_h, wr_b}, 0);
    end

    // single step table
    for (int i = 0; i < 7; i++) begin
      up = sv[i].up;
      run = 1'b0;
      do_load(sv[i].st);
      run = 1'b1;
      nclk(3);
      chk($sformatf("pre_h[%0d]", i), 32'(do_h),
          32'(mk(sv[i].st, 2'b00)));
      chk($sformatf("pre_b[%0d]", i), 32'(do_b),
          32'(mk(sv[i].bst, 2'b00)));
      nclk(1);
      chk($sformatf("st_h[%0d]", i), 32'(do_h),
          32'(mk(sv[i].hx, 2'b00)));
      chk($sformatf("st_b[%0d]", i), 32'(do_b),
          32'(mk(sv[i].bc, 2'b00)));
      chk($sformatf("wr_h[%0d]", i), 32'(wr_h), 32'(sv[i].hw));
      chk($sformatf("wr_b[%0d]", i), 32'(wr_b), 32'(sv[i].bw));
      run = 1'b0;
      nclk(1);
      chk($sformatf("wr_end[%0d]", i), {wr_h, wr_b}, 0);
    end

    // hex FF up then down, back-to-back
    up = 1'b1;
    do_load(8'hFF);
    run = 1'b1;
    nclk(4);
    chk("ff_up", 32'(do_h), 32'(mk(8'h00, 2'b00)));
    chk("ff_up_w", 32'(wr_h), 1);
    up = 1'b0;
    nclk(3);
    chk("dn_pre_w", 32'(wr_h), 0);
    nclk(1);
    chk("dn_ff", 32'(do_h), 32'(mk(8'hFF, 2'b00)));
    chk("dn_ff_w", 32'(wr_h), 1);

    // load coincident with count_tick
    run = 1'b0;
    up = 1'b1;
    do_load(8'h00);
    run = 1'b1;
    nclk(3);
    chk("coin_ct", 32'(ct_h), 1);
    do_load(8'h42);
    chk("coin_ld", 32'(do_h), 32'(mk(8'h42, 2'b00)));
    chk("coin_w", 32'(wr_h), 0);
    nclk(3);
    chk("coin_hold", 32'(do_h), 32'(mk(8'h42, 2'b00)));
    nclk(1);
    chk("coin_next", 32'(do_h), 32'(mk(8'h43, 2'b00)));

    // pause mid-period
    run = 1'b0;
    do_load(8'h10);
    run = 1'b1;
    nclk(2);
    run = 1'b0;
    sc = 0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("pz_ct[%0d]", i), 32'(ct_h), 0);
      nclk(1);
      if (st_h) sc++;
      chk($sformatf("pz_v[%0d]", i), 32'(do_h),
          32'(mk(8'h10, 2'b00)));
    end
    chk("pz_scan", sc, 5);
    run = 1'b1;
    nclk(1);
    chk("rs_ct", 32'(ct_h), 1);
    chk("rs_hold", 32'(do_h), 32'(mk(8'h10, 2'b00)));
    nclk(1);
    chk("rs_step", 32'(do_h), 32'(mk(8'h11, 2'b00)));

    // async reset mid-count, then dp latency
    run = 1'b0;
    do_load(8'h37);
    dp_en = 2'b01;
    run = 1'b1;
    nclk(1);
    @(posedge clk_50MHz);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_h", 32'(do_h), 32'h210);
    chk("ar_b", 32'(do_b), 32'h210);
    chk("ar_w", {wr_h, ct_h, st_h}, 0);
    run = 1'b0;
    nclk(1);
    rst_n = 1'b1;
    nclk(1);
    chk("dp0", 32'(do_h), 32'h200);
    dp_en = 2'b10;
    chk("dp_lag", 32'(do_h), 32'h200);
    nclk(1);
    chk("dp1", 32'(do_b), 32'h010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
